// File: rtl/slow_clock_receiver_if.sv
// Bundle between the slow-clock receiver and its user:
// slow input, mode/halt controls, tick enable and period readout.
interface slow_clock_receiver_if #(
  parameter int unsigned CNT_W = 16
);
  logic             slow_in;
  logic             mode;
  logic             halt;
  logic             tick;
  logic             level;
  logic [CNT_W-1:0] tick_count;
  logic [31:0]      period;
  logic             period_valid;

  modport master (
    output slow_in, mode, halt,
    input  tick, level, tick_count,
    input  period, period_valid
  );

  modport slave (
    input  slow_in, mode, halt,
    output tick, level, tick_count,
    output period, period_valid
  );
endinterface

// File: rtl/slow_clock_receiver.sv
// Brings a slow clock or step button into clk_in as a one-cycle
// tick enable, with optional debounce and period measurement.
module slow_clock_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] DEBOUNCE    = 32'd100000,
  parameter int unsigned CNT_W       = 16
) (
  input logic                  clk_in,
  input logic                  rst_n,
  slow_clock_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHK_HIGH,
    STABLE_HIGH,
    CHK_LOW
  } db_state_e;

  db_state_e              state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   mode_q;
  logic                   mode_chg;
  logic [31:0]            db_cnt;
  logic [31:0]            pcnt;
  logic [31:0]            pcnt_inc;
  logic                   level;
  logic                   level_d;
  logic                   rise;
  logic                   first_seen;
  logic                   tick;
  logic                   period_valid;
  logic [CNT_W-1:0]       tick_count;
  logic [31:0]            period;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign mode_chg = bus.mode != mode_q;
  assign rise     = level & ~level_d;
  assign pcnt_inc = (pcnt == '1) ? pcnt
                                 : pcnt + 32'd1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= STABLE_LOW;
      sync_q       <= '0;
      mode_q       <= 1'b0;
      db_cnt       <= '0;
      pcnt         <= '0;
      level        <= 1'b0;
      level_d      <= 1'b0;
      first_seen   <= 1'b0;
      tick         <= 1'b0;
      period_valid <= 1'b0;
      tick_count   <= '0;
      period       <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.slow_in};
      mode_q  <= bus.mode;
      level_d <= level;
      tick    <= 1'b0;
      pcnt    <= pcnt_inc;
      if (mode_chg) begin
        // re-seat everything on the current level so
        // the switch itself can never look like an edge
        level        <= sync;
        level_d      <= sync;
        state        <= sync ? STABLE_HIGH : STABLE_LOW;
        db_cnt       <= '0;
        pcnt         <= '0;
        period_valid <= 1'b0;
        first_seen   <= 1'b0;
      end else begin
        if (rise) begin
          tick   <= ~bus.halt;
          period <= pcnt_inc;
          pcnt   <= '0;
          first_seen <= 1'b1;
          if (!bus.halt)
            tick_count <= tick_count + 1'b1;
          if (first_seen)
            period_valid <= 1'b1;
        end
        if (!mode_q)
          level <= sync;
        unique case (state)
          STABLE_LOW: begin
            if (sync) begin
              state  <= CHK_HIGH;
              db_cnt <= '0;
            end
          end
          CHK_HIGH: begin
            if (!sync) begin
              state <= STABLE_LOW;
            end else if (db_cnt == DEBOUNCE - 32'd1) begin
              state <= STABLE_HIGH;
              if (mode_q)
                level <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 32'd1;
            end
          end
          STABLE_HIGH: begin
            if (!sync) begin
              state  <= CHK_LOW;
              db_cnt <= '0;
            end
          end
          CHK_LOW: begin
            if (sync) begin
              state <= STABLE_HIGH;
            end else if (db_cnt == DEBOUNCE - 32'd1) begin
              state <= STABLE_LOW;
              if (mode_q)
                level <= 1'b0;
            end else begin
              db_cnt <= db_cnt + 32'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.tick         = tick;
  assign bus.level        = level;
  assign bus.tick_count   = tick_count;
  assign bus.period       = period;
  assign bus.period_valid = period_valid;

endmodule

// File: tb/tb_slow_clock_receiver.sv
// Directed bench for slow_clock_receiver: latency, debounce,
// halt, mode switch, async reset, wrap and period saturation.
module tb_slow_clock_receiver;

  logic clk_in = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;
  int   ntick = 0;
  int   last_t = 0;
  int   prev_t = 0;
  int   b;

  always #5 clk_in = ~clk_in;

  slow_clock_receiver_if #(.CNT_W(4)) bus ();

  slow_clock_receiver #(
    .SYNC_STAGES(2),
    .DEBOUNCE   (32'd8),
    .CNT_W      (4)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(negedge clk_in) begin
    cyc_n++;
    if (bus.tick) begin
      ntick++;
      prev_t = last_t;
      last_t = cyc_n;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    bus.slow_in = 1'b1;
    cyc(hi);
    bus.slow_in = 1'b0;
    cyc(lo);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_tick"}, 32'(bus.tick), 0);
    check({pfx, "_level"}, 32'(bus.level), 0);
    check({pfx, "_cnt"}, 32'(bus.tick_count), 0);
    check({pfx, "_period"}, bus.period, 0);
    check({pfx, "_pv"}, 32'(bus.period_valid), 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.slow_in = 1'b0;
    bus.mode    = 1'b0;
    bus.halt    = 1'b0;
    cyc(2);
    check_zero("rst");
    rst_n = 1'b1;
    cyc(5);

    // run-mode latency: tick after edge E0+3
    bus.slow_in = 1'b1;
    cyc(1);
    cyc(2);
    check("lat_pre", 32'(bus.tick), 0);
    cyc(1);
    check("lat_tick", 32'(bus.tick), 1);
    check("lat_cnt", 32'(bus.tick_count), 1);
    check("pv_first", 32'(bus.period_valid), 0);
    cyc(1);
    check("tick_1cyc", 32'(bus.tick), 0);
    bus.slow_in = 1'b0;
    cyc(10);

    // 10-cycle square wave
    b = ntick;
    bus.slow_in = 1'b1;
    cyc(5);
    check("pv_2nd", 32'(bus.period_valid), 1);
    bus.slow_in = 1'b0;
    cyc(5);
    repeat (3) pulse(5, 5);
    check("run_ticks", ntick - b, 4);
    check("run_cnt", 32'(bus.tick_count), 5);
    check("run_period", bus.period, 10);
    check("run_space", last_t - prev_t, 10);

    // halt drops edges but keeps measuring
    bus.halt = 1'b1;
    b = ntick;
    repeat (3) pulse(5, 5);
    check("halt_ticks", ntick - b, 0);
    check("halt_cnt", 32'(bus.tick_count), 5);
    check("halt_period", bus.period, 10);
    bus.halt = 1'b0;
    pulse(5, 5);
    check("rel_ticks", ntick - b, 1);
    check("rel_cnt", 32'(bus.tick_count), 6);

    // mode switch while input high
    bus.slow_in = 1'b1;
    cyc(6);
    check("pre_ms_cnt", 32'(bus.tick_count), 7);
    bus.mode = 1'b1;
    b = ntick;
    cyc(11);
    check("ms_ticks", ntick - b, 0);
    check("ms_pv", 32'(bus.period_valid), 0);
    check("ms_level", 32'(bus.level), 1);
    check("ms_pcnt", dut.pcnt, 10);
    bus.slow_in = 1'b0;
    cyc(20);
    bus.slow_in = 1'b1;
    cyc(20);
    check("ms_rise", ntick - b, 1);
    check("ms_pv1", 32'(bus.period_valid), 0);
    bus.slow_in = 1'b0;
    cyc(20);
    bus.slow_in = 1'b1;
    cyc(20);
    check("ms_pv2", 32'(bus.period_valid), 1);
    check("ms_period", bus.period, 40);
    check("ms_cnt", 32'(bus.tick_count), 9);

    // step-mode debounce, DEBOUNCE=8
    bus.slow_in = 1'b0;
    cyc(20);
    check("st_low", 32'(bus.level), 0);
    b = ntick;
    bus.slow_in = 1'b1;
    cyc(5);
    bus.slow_in = 1'b0;
    cyc(20);
    check("gl_ticks", ntick - b, 0);
    check("gl_level", 32'(bus.level), 0);
    bus.slow_in = 1'b1;
    cyc(1);
    cyc(10);
    check("st_pre", 32'(bus.tick), 0);
    cyc(1);
    check("st_tick", 32'(bus.tick), 1);
    cyc(7);
    bus.slow_in = 1'b0;
    cyc(20);
    check("st_one", ntick - b, 1);
    check("st_cnt", 32'(bus.tick_count), 10);

    // async reset mid-pulse in run mode
    bus.mode = 1'b0;
    cyc(3);
    bus.slow_in = 1'b1;
    cyc(4);
    check("rs_pre_tick", 32'(bus.tick), 1);
    check("rs_pre_cnt", 32'(bus.tick_count), 11);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("arst");
    #2;
    rst_n = 1'b1;
    b = ntick;
    cyc(6);
    check("rs_retick", ntick - b, 1);
    check("rs_cnt", 32'(bus.tick_count), 1);

    // toggle every cycle: tick every 2, count wraps
    bus.slow_in = 1'b0;
    cyc(4);
    repeat (16) pulse(1, 1);
    cyc(6);
    check("wr_ticks", ntick - b, 17);
    check("wr_cnt", 32'(bus.tick_count), 1);
    check("wr_space", last_t - prev_t, 2);

    // period saturation
    cyc(5);
    pulse(5, 3);
    force dut.pcnt = 32'hFFFF_FFFC;
    cyc(1);
    release dut.pcnt;
    cyc(6);
    bus.slow_in = 1'b1;
    cyc(5);
    check("sat_period", bus.period, 32'hFFFF_FFFF);
    check("sat_pv", 32'(bus.period_valid), 1);
    bus.slow_in = 1'b0;
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/slow_clock_receiver.md
# slow_clock_receiver

Receive side of the divided-clock path: takes a slow, asynchronous clock-like signal (a divided clock or a manual step button) into the fast `clk_in` domain and turns each qualified rising edge into a single-cycle `tick` clock-enable. The processor core is clocked by `clk_in` and advances on `tick`, so no logic runs on a derived clock. The block also measures the period of the incoming signal in `clk_in` cycles, so the divider ratio can be checked on the board.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth; legal values 2 to 4.
- `DEBOUNCE`, default 32'd100000: number of consecutive stable samples required to accept a level change in step mode; minimum 1.
- `CNT_W`, default 16: width of `tick_count`.
- `clk_in` in, 1 bit: fast system clock.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `slow_in` in, 1 bit: asynchronous slow clock or button input.
- `mode` in, 1 bit: 0 = run, where the synchronized level is used directly; 1 = step, where the level is debounced.
- `halt` in, 1 bit: suppresses `tick` generation; level tracking and period measurement continue.
- `tick` out, 1 bit: one-cycle pulse per accepted rising edge.
- `level` out, 1 bit: accepted level, synchronized and debounced if in step mode.
- `tick_count` out, CNT_W bits: number of ticks issued; wraps modulo 2^CNT_W.
- `period` out, 32 bits: `clk_in` cycles between the last two accepted rising edges.
- `period_valid` out, 1 bit: `period` holds a real measurement.

## Operation
- **Synchronizer:** `slow_in` passes through a `SYNC_STAGES` flop chain. The last stage is `sync`.
- **Run mode (`mode`=0):** `level` <= `sync` every cycle.
- **Step mode (`mode`=1):** debounce FSM with states STABLE_LOW, CHK_HIGH, STABLE_HIGH, CHK_LOW.
  - STABLE_LOW: `sync`=1 moves to CHK_HIGH with `db_cnt`=0.
  - CHK_HIGH: if `sync`=0, return to STABLE_LOW. Otherwise increment `db_cnt`. When `db_cnt` reaches DEBOUNCE-1, move to STABLE_HIGH and set `level`<=1.
  - STABLE_HIGH and CHK_LOW mirror STABLE_LOW and CHK_HIGH.
  - A glitch shorter than DEBOUNCE cycles never changes `level`.
- **Edge detect:** `rise` = `level` & ~`level_d`, where `level_d` is `level` delayed one cycle.
- **Tick:** on `rise` with `halt`=0:
  - `tick`<=1 for exactly one cycle;
  - `tick_count` increments.
  - A rising edge that occurs while `halt`=1 is dropped. It is not deferred and does not tick when `halt` is released.
- **Period counter:** `pcnt` increments every cycle and saturates at 32'hFFFFFFFF.
  - On `rise`: `period`<=`pcnt`+1 (saturating), then `pcnt`<=0.
  - `period_valid` is set on the second `rise` after reset or after a mode change. It stays set until the next reset or mode change.
- **Mode change:** any cycle where `mode` differs from its registered copy does the following:
  - forces `level`<=`sync` and `level_d`<=`sync`, so the switch itself never produces a `rise`;
  - forces the FSM to STABLE_HIGH or STABLE_LOW to match `sync`;
  - clears `pcnt`, `period_valid` and the first-edge flag.

## Timing
- **Reset values:** `tick`=0, `level`=0, `tick_count`=0, `period`=0, `period_valid`=0. Sync chain, `level_d`, `pcnt` and `db_cnt` are 0. FSM is in STABLE_LOW.
- **Run-mode latency:** edge E0 is the first `clk_in` edge that samples `slow_in`=1. `tick` is high in the cycle after edge E0+SYNC_STAGES+1, i.e. SYNC_STAGES+2 edges after E0 (4 with the default depth).
- **Step-mode latency:** the run-mode latency plus DEBOUNCE cycles.
- **Back-to-back edges:** the minimum spacing between ticks is 2 cycles, since `level` must fall for at least one cycle. A `slow_in` that toggles every `clk_in` cycle in run mode produces a tick every 2 cycles.
- **Reset during operation:** asserting `rst_n` low clears all state immediately, with no clock needed. After release, the first `rise` needs `slow_in` to be seen low for at least one cycle. If `slow_in` is already high at release, one tick follows at the normal latency.
- **Counter wrap:** `tick_count` goes from all-ones to 0 and nothing else is flagged.
- **Simultaneous events:** if `rise` and `halt`=1 occur in the same cycle, `period` still updates and `tick` stays 0. If `rise` and a mode change occur in the same cycle, the mode change wins: no tick, no period update.

## Test plan
- **Run mode, periodic input:** `slow_in` square wave with period 10 cycles, `mode`=0, `halt`=0, default parameters. Expect:
  - first `tick` 4 cycles after the first sampled high;
  - then one `tick` every 10 cycles;
  - `period`=10, with `period_valid` going high on the 2nd edge;
  - `tick_count`=5 after 5 edges.
- **Step-mode debounce:** `DEBOUNCE`=8, `mode`=1. A 5-cycle high glitch gives no tick and `level` stays 0. A 20-cycle high pulse gives exactly one `tick`, 12 cycles after the first sampled high.
- **Halt:** `halt`=1 across 3 edges of a 10-cycle square wave. Expect no ticks, `tick_count` unchanged, `period` still 10. On release, the next edge ticks normally.
- **Mode switch with `slow_in` high:** toggle `mode` while `slow_in`=1. Expect no tick, `period_valid`=0, `pcnt` cleared. The next rising edge ticks and the one after that restores `period_valid`.
- **Reset during operation and wrap:** pull `rst_n` low mid-pulse. All outputs go to 0 asynchronously. With `CNT_W`=4, 17 edges leave `tick_count`=1.
- **Saturation:** hold `slow_in` low for more than 2^32 cycles (force `pcnt` near its maximum), then apply 2 edges. Expect `period`=32'hFFFFFFFF.
